fetch_queue: RTL and testbench

- Next-generation on-core fetch unit: decoupled prefetcher with a parametrised instruction queue, request/acknowledge bus handshake, and a redirect (branch/exception) flush path.
- Sits between the core bus port and decode.
- Fetches ahead sequentially while queue space exists.
- Hands instructions and their PCs to decode over a valid/ready handshake.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 78 +++++++
 rtl/fetch_queue.sv | 154 +++++++++++++++
 tb/tb_fetch_queue.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the fetch unit: FSM state encoding, the queue entry layout
// and the instruction size used to advance the fetch PC.
// Optional bus-error support is enabled with FETCH_QUEUE_BUS_ERR_EN.
package fetch_pkg;

  localparam int INST_BYTES = 4;
  localparam int DEF_AD_LEN = 32;
  localparam int DEF_INST_W = 32;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_e;

  // Queue entry at the default 32-bit address/data widths.
  typedef struct packed {
`ifdef FETCH_QUEUE_BUS_ERR_EN
    logic                  fault;
`endif
    logic [DEF_AD_LEN-1:0] pc;
    logic [DEF_INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO with push/pop/flush. The head entry is held in
// its own register so the consumer sees a registered output; when the FIFO
// drains or is flushed the head register keeps its last value.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     head_q, head_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && (count_q != CNT_W'(DEPTH));

  // Next pointers/count and the value the head register should present.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      // Incoming word becomes head when nothing older will remain.
      if (do_push && ((count_q == '0) || ((count_q == CNT_W'(1)) && do_pop)))
        head_d = push_data_i;
      else if (do_pop && (count_q > CNT_W'(1)))
        head_d = mem_q[rd_ptr_d];
    end
  end

  // Storage array write port (no reset, maps to RAM).
  always_ff @(posedge clk_i) begin
    if (reset_ni && do_push && !flush_i)
      mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointer, count and head registers.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = head_q;

endmodule

// File: rtl/fetch_queue.sv
// Decoupled instruction prefetcher: one outstanding bus request at a time,
// results queued in fetch_fifo and handed to decode over valid/ready.
// A redirect flushes the queue and restarts fetching at the new PC; a request
// already on the bus is completed and its data dropped.
// Defining FETCH_QUEUE_BUS_ERR_EN adds bus_err_i/inst_fault_o: an erroring
// ack queues a faulted entry and halts fetching until the next redirect.
import fetch_pkg::*;

module fetch_queue #(
  parameter int                AD_LEN   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [AD_LEN-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  output logic              bus_req_o,
  output logic [AD_LEN-1:0] bus_ad_o,
  input  logic              bus_ack_i,
  input  logic [INST_W-1:0] bus_data_i,
`ifdef FETCH_QUEUE_BUS_ERR_EN
  input  logic              bus_err_i,
  output logic              inst_fault_o,
`endif
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [AD_LEN-1:0] inst_pc_o,
  input  logic              redirect_i,
  input  logic [AD_LEN-1:0] redirect_pc_i
);

  typedef struct packed {
`ifdef FETCH_QUEUE_BUS_ERR_EN
    logic              fault;
`endif
    logic [AD_LEN-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  fetch_state_e      state_q, state_d;
  logic [AD_LEN-1:0] pc_q, pc_d;
  logic [AD_LEN-1:0] ad_q, ad_d;
  logic [AD_LEN-1:0] redirect_pc;
  logic              push;
  entry_t            push_entry;
  entry_t            head_entry;
  logic              fifo_full, fifo_empty;
  logic              can_fetch;

  // Redirect targets are word aligned; the low two bits are discarded.
  assign redirect_pc = redirect_pc_i & ~AD_LEN'(3);

`ifdef FETCH_QUEUE_BUS_ERR_EN
  logic halt_q, halt_d;
  assign can_fetch = !fifo_full && !halt_q;
`else
  assign can_fetch = !fifo_full;
`endif

  // Fetch FSM: request issue, ack handling, redirect/discard.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    ad_d            = ad_q;
    push            = 1'b0;
    push_entry      = '0;
    push_entry.pc   = ad_q;
    push_entry.inst = bus_data_i;
`ifdef FETCH_QUEUE_BUS_ERR_EN
    halt_d          = halt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!redirect_i && can_fetch) begin
          state_d = S_REQ;
          ad_d    = pc_q;
        end
      end
      S_REQ: begin
        if (redirect_i) begin
          // Bus cannot drop a request: wait out the ack unless it is here now.
          state_d = bus_ack_i ? S_IDLE : S_DISCARD;
        end else if (bus_ack_i) begin
          push    = 1'b1;
          state_d = S_IDLE;
          pc_d    = pc_q + AD_LEN'(INST_BYTES);
`ifdef FETCH_QUEUE_BUS_ERR_EN
          if (bus_err_i) begin
            push_entry.fault = 1'b1;
            push_entry.inst  = '0;
            halt_d           = 1'b1;
          end
`endif
        end
      end
      S_DISCARD: begin
        if (bus_ack_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Redirect always wins the PC; the latest one seen is kept.
    if (redirect_i) begin
      pc_d = redirect_pc;
`ifdef FETCH_QUEUE_BUS_ERR_EN
      halt_d = 1'b0;
`endif
    end
  end

  // FSM state, fetch PC and bus address registers.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ad_q    <= '0;
`ifdef FETCH_QUEUE_BUS_ERR_EN
      halt_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ad_q    <= ad_d;
`ifdef FETCH_QUEUE_BUS_ERR_EN
      halt_q  <= halt_d;
`endif
    end
  end

  fetch_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (inst_valid_o && inst_ready_i),
    .flush_i     (redirect_i),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head_entry)
  );

  assign bus_req_o    = (state_q != S_IDLE);
  assign bus_ad_o     = ad_q;
  assign inst_valid_o = !fifo_empty;
  assign inst_o       = head_entry.inst;
  assign inst_pc_o    = head_entry.pc;
`ifdef FETCH_QUEUE_BUS_ERR_EN
  assign inst_fault_o = head_entry.fault;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios followed by a randomized run, all
// checked cycle by cycle against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_fetch_queue;

  localparam int          AD_LEN   = 32;
  localparam int          INST_W   = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        bus_req;
  logic [31:0] bus_ad;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
`ifdef FETCH_QUEUE_BUS_ERR_EN
  logic        bus_err = 1'b0;
  logic        inst_fault;
`endif

  always #5 clk = ~clk;

  fetch_queue #(
    .AD_LEN   (AD_LEN),
    .INST_W   (INST_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk_i         (clk),
    .reset_ni      (reset_n),
    .bus_req_o     (bus_req),
    .bus_ad_o      (bus_ad),
    .bus_ack_i     (bus_ack),
    .bus_data_i    (bus_data),
`ifdef FETCH_QUEUE_BUS_ERR_EN
    .bus_err_i     (bus_err),
    .inst_fault_o  (inst_fault),
`endif
    .inst_valid_o  (inst_valid),
    .inst_ready_i  (inst_ready),
    .inst_o        (inst),
    .inst_pc_o     (inst_pc),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } ent_t;

  // Behavioural model: queue contents plus bus-side bookkeeping.
  ent_t        mq[$];
  logic        m_req, m_disc, m_halt;
  logic [31:0] m_pc, m_ad;
  ent_t        m_last;
  int          req_age;

  int          errors = 0;
  int          checks = 0;
  int          ack_mode = 0;   // 0 none, 1 same cycle, 2 one cycle late, 3 random
  logic        err_arm = 1'b0;
  logic        err_rand = 1'b0;
  logic [31:0] err_addr = '0;
  logic        verbose = 1'b1;
  int          reqs_seen = 0;
  logic [31:0] last_req_ad = '0;
  logic        prev_req_obs = 1'b0;
  logic [31:0] deliv[$];
  int          n;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, compare.
  task automatic step(input logic rstn, input logic rdy, input logic redir, input logic [31:0] rpc);
    logic        ack;
    logic        err;
    logic [31:0] data;
    logic        pop;
    logic        accept;
    int          pre_size;
    ent_t        e;
    data = $urandom;
    case (ack_mode)
      1:       ack = m_req;
      2:       ack = m_req && (req_age >= 1);
      3:       ack = m_req && ($urandom_range(0, 2) == 0);
      default: ack = 1'b0;
    endcase
    err = 1'b0;
`ifdef FETCH_QUEUE_BUS_ERR_EN
    err = ack && ((err_arm && (m_ad == err_addr)) || (err_rand && ($urandom_range(0, 19) == 0)));
    bus_err = err;
`endif
    reset_n     = rstn;
    inst_ready  = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    bus_ack     = ack;
    bus_data    = data;
    if (rstn && inst_valid && rdy) begin
      deliv.push_back(inst_pc);
      if (verbose) $display("deliver pc=%08h inst=%08h", inst_pc, inst);
    end
    @(posedge clk);
    pre_size = mq.size();
    if (!rstn) begin
      mq.delete();
      m_req   = 1'b0;
      m_disc  = 1'b0;
      m_halt  = 1'b0;
      m_pc    = RESET_PC;
      m_ad    = '0;
      m_last  = '{pc: '0, inst: '0, fault: 1'b0};
      req_age = 0;
    end else begin
      pop    = (pre_size != 0) && rdy;
      accept = m_req && ack && !m_disc && !redir;
      if (redir) mq.delete();
      else begin
        if (pop) void'(mq.pop_front());
        if (accept) begin
          e.pc    = m_ad;
          e.inst  = err ? 32'h0 : data;
          e.fault = err;
          mq.push_back(e);
        end
      end
      if (m_req) begin
        if (ack) begin
          m_req  = 1'b0;
          m_disc = 1'b0;
        end else begin
          if (redir) m_disc = 1'b1;
          req_age++;
        end
      end else if (!redir && (pre_size < DEPTH) && !m_halt) begin
        m_req   = 1'b1;
        m_ad    = m_pc;
        req_age = 0;
      end
      if (accept) begin
        m_pc = m_pc + 32'd4;
        if (err) m_halt = 1'b1;
      end
      if (redir) begin
        m_pc   = rpc & 32'hFFFF_FFFC;
        m_halt = 1'b0;
      end
    end
    if (mq.size() != 0) m_last = mq[0];
    #1;
    check("bus_req", bus_req, m_req);
    if (m_req || !rstn) check("bus_ad", bus_ad, m_ad);
    check("inst_valid", inst_valid, mq.size() != 0);
    check("inst", inst, m_last.inst);
    check("inst_pc", inst_pc, m_last.pc);
`ifdef FETCH_QUEUE_BUS_ERR_EN
    check("inst_fault", inst_fault, m_last.fault);
`endif
    if (bus_req && !prev_req_obs) begin
      reqs_seen++;
      last_req_ad = bus_ad;
      if (verbose) $display("request ad=%08h", bus_ad);
    end
    prev_req_obs = bus_req;
  endtask

  initial begin
    // Reset state
    repeat (3) step(0, 0, 0, 0);
    check("rst_req", bus_req, 0);
    check("rst_ad", bus_ad, 0);
    check("rst_valid", inst_valid, 0);

    // A: in-order delivery, ack one cycle after request
    ack_mode = 2;
    deliv.delete();
    repeat (20) step(1, 1, 0, 0);
    check("A_count", deliv.size() >= 3, 1);
    for (int i = 0; i < 3; i++)
      check("A_pc", (deliv.size() > i) ? deliv[i] : 32'hDEAD_BEEF, 32'(4 * i));

    // B: decode stalled, queue fills after 4 requests, one dequeue frees a slot
    ack_mode = 1;
    step(0, 0, 0, 0);
    reqs_seen = 0;
    repeat (30) step(1, 0, 0, 0);
    check("B_reqs", reqs_seen, 4);
    check("B_last_ad", last_req_ad, 32'hC);
    check("B_idle", bus_req, 0);
    step(1, 1, 0, 0);
    repeat (6) step(1, 0, 0, 0);
    check("B_reqs2", reqs_seen, 5);
    check("B_next_ad", last_req_ad, 32'h10);

    // C: redirect while a request is pending
    ack_mode = 0;
    step(0, 0, 0, 0);
    deliv.delete();
    n = 0;
    while (!bus_req && n < 10) begin step(1, 1, 0, 0); n++; end
    check("C_req_up", bus_req, 1);
    step(1, 1, 1, 32'h103);
    repeat (3) step(1, 1, 0, 0);
    check("C_req_held", bus_req, 1);
    check("C_ad_held", bus_ad, 32'h0);
    ack_mode = 1;
    step(1, 1, 0, 0);
    ack_mode = 0;
    check("C_dropped", inst_valid, 0);
    n = 0;
    while (!bus_req && n < 10) begin step(1, 1, 0, 0); n++; end
    check("C_new_ad", bus_ad, 32'h100);
    ack_mode = 2;
    repeat (10) step(1, 1, 0, 0);
    check("C_first_pc", (deliv.size() > 0) ? deliv[0] : 32'hDEAD_BEEF, 32'h100);

    // D: redirect with three entries queued
    ack_mode = 1;
    step(0, 0, 0, 0);
    n = 0;
    while (mq.size() < 3 && n < 30) begin step(1, 0, 0, 0); n++; end
    check("D_fill_in_time", n < 30, 1);
    check("D_valid_before", inst_valid, 1);
    step(1, 0, 1, 32'h200);
    check("D_valid_cleared", inst_valid, 0);
    deliv.delete();
    ack_mode = 2;
    repeat (12) step(1, 1, 0, 0);
    check("D_first_pc", (deliv.size() > 0) ? deliv[0] : 32'hDEAD_BEEF, 32'h200);

    // E: reset in the middle of a request, ack during reset ignored
    ack_mode = 0;
    n = 0;
    while (!bus_req && n < 10) begin step(1, 1, 0, 0); n++; end
    check("E_req_up", bus_req, 1);
    ack_mode = 1;
    step(0, 1, 0, 0);
    check("E_req0", bus_req, 0);
    check("E_ad0", bus_ad, 0);
    check("E_valid0", inst_valid, 0);
    check("E_inst0", inst, 0);
    check("E_pc0", inst_pc, 0);
    ack_mode = 0;
    n = 0;
    step(1, 1, 0, 0);
    while (!bus_req && n < 10) begin step(1, 1, 0, 0); n++; end
    check("E_first_ad", bus_ad, RESET_PC);

`ifdef FETCH_QUEUE_BUS_ERR_EN
    // G: erroring ack at 0x8 halts fetching until redirect
    ack_mode = 2;
    step(0, 0, 0, 0);
    reqs_seen = 0;
    err_addr  = 32'h8;
    err_arm   = 1'b1;
    repeat (25) step(1, 0, 0, 0);
    check("G_reqs", reqs_seen, 3);
    check("G_halted", bus_req, 0);
    repeat (2) step(1, 1, 0, 0);
    check("G_fault", inst_fault, 1);
    check("G_fault_pc", inst_pc, 32'h8);
    check("G_fault_data", inst, 0);
    err_arm = 1'b0;
    step(1, 1, 1, 32'h40);
    n = 0;
    while (!bus_req && n < 10) begin step(1, 1, 0, 0); n++; end
    check("G_resume_ad", bus_ad, 32'h40);
    err_rand = 1'b1;
`endif

    // F: randomized traffic
    verbose  = 1'b0;
    ack_mode = 3;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) != 0,
           ((i / 400) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
           $urandom_range(0, 29) == 0,
           $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
